text_buffer_ctrl: RTL

Write-side controller for the 80×48 character RAM (3840 bytes, 12-bit address) of the VGA text terminal. It accepts a stream of 8-bit character codes over a valid/ready handshake and tracks the cursor. It translates control codes into RAM writes and sequences full-screen and single-row clears. It is the only writer of the character RAM; the display side reads it independently.

---
 rtl/text_buffer_ctrl_if.sv | 23 ++
 rtl/text_buffer_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl_if.sv
// Character stream handshake and character-RAM write bus of the text terminal.
interface text_buffer_ctrl_if #(
   parameter int unsigned AW = 12
);
   logic          char_valid;
   logic [7:0]    char_data;
   logic          char_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   // Character source that also observes the RAM write port.
   modport master (
      output char_valid, char_data,
      input  char_ready, wr_en, wr_addr, wr_data
   );

   // Buffer controller.
   modport slave (
      input  char_valid, char_data,
      output char_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Write-side controller of the 80x48 character RAM: consumes character codes, tracks the
// cursor, and sequences full-screen and single-row clears.
module text_buffer_ctrl #(
   parameter int unsigned COLS  = 80,
   parameter int unsigned ROWS  = 48,
   parameter int unsigned DEPTH = COLS * ROWS,
   parameter int unsigned AW    = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   text_buffer_ctrl_if.slave  bus,
   input  logic               clear_req,
   output logic               busy,
   output logic [6:0]         cur_col,
   output logic [5:0]         cur_row
);

   typedef enum logic [1:0] {StFullClr, StIdle, StRowClr} state_e;

   localparam logic [6:0]    ColLast  = 7'(COLS - 1);
   localparam logic [5:0]    RowLast  = 6'(ROWS - 1);
   localparam logic [AW-1:0] AddrLast = AW'(DEPTH - 1);
   localparam logic [AW-1:0] RowClrLast = AW'(COLS - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [6:0]    col_q, col_d;
   logic [5:0]    row_q, row_d;
   logic          pend_q, pend_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [5:0]    row_nxt;

   // row*80 built from two shifts; the largest cell is 47*80+79 = 3839.
   function automatic logic [AW-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
      logic [AW-1:0] r;
      r = AW'(row);
      return (r << 6) + (r << 4) + AW'(col);
   endfunction

   // Next state, cursor movement and the write scheduled for the following cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      col_d     = col_q;
      row_d     = row_q;
      pend_d    = pend_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      row_nxt   = (row_q == RowLast) ? 6'd0 : row_q + 6'd1;

      case (state_q)
         StFullClr: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = 8'h00;
            cnt_d     = cnt_q + AW'(1);
            if (cnt_q == AddrLast) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end

         StIdle: begin
            if (clear_req) begin
               state_d = StFullClr;
               cnt_d   = '0;
               col_d   = '0;
               row_d   = '0;
               pend_d  = 1'b0;
            end else if (bus.char_valid) begin
               if (bus.char_data >= 8'h20 && bus.char_data <= 8'h7E) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cell_addr(row_q, col_q);
                  wr_data_d = bus.char_data;
                  if (col_q != ColLast) begin
                     col_d = col_q + 7'd1;
                  end else begin
                     col_d   = '0;
                     row_d   = row_nxt;
                     cnt_d   = '0;
                     state_d = StRowClr;
                  end
               end else begin
                  case (bus.char_data)
                     8'h0A, 8'h0D: begin
                        col_d   = '0;
                        row_d   = row_nxt;
                        cnt_d   = '0;
                        state_d = StRowClr;
                     end
                     8'h08: begin
                        if (col_q != 7'd0) begin
                           col_d     = col_q - 7'd1;
                           wr_en_d   = 1'b1;
                           wr_addr_d = cell_addr(row_q, col_q - 7'd1);
                           wr_data_d = 8'h00;
                        end else if (row_q != 6'd0) begin
                           row_d     = row_q - 6'd1;
                           col_d     = ColLast;
                           wr_en_d   = 1'b1;
                           wr_addr_d = cell_addr(row_q - 6'd1, ColLast);
                           wr_data_d = 8'h00;
                        end
                     end
                     8'h0C: begin
                        state_d = StFullClr;
                        cnt_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                        pend_d  = 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end

         StRowClr: begin
            // Cursor already sits in the row being cleared, so row_q gives the base.
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(row_q, 7'd0) + cnt_q;
            wr_data_d = 8'h00;
            cnt_d     = cnt_q + AW'(1);
            if (clear_req) begin
               pend_d = 1'b1;
            end
            if (cnt_q == RowClrLast) begin
               cnt_d = '0;
               if (pend_q || clear_req) begin
                  state_d = StFullClr;
                  col_d   = '0;
                  row_d   = '0;
                  pend_d  = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         default: state_d = StFullClr;
      endcase
   end

   // State, cursor and registered write port; reset starts a full clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFullClr;
         cnt_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         pend_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         col_q     <= col_d;
         row_q     <= row_d;
         pend_q    <= pend_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.char_ready = (state_q == StIdle) & ~clear_req;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign busy           = (state_q != StIdle);
   assign cur_col        = col_q;
   assign cur_row        = row_q;

endmodule
